// File: rtl/run_gen_pkg.sv
// rtl/run_gen_pkg.sv - shared types for the serial run generator
package run_gen_pkg;

  // 2'b11 is never entered; next-state logic returns it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/run_gen.sv
// rtl/run_gen.sv - drives q high for start_len cycles per request, then holds it low for GAP cycles
module run_gen #(
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  input  logic [LEN_W-1:0] start_len,
  output logic             start_ready,
  output logic             q,
  output logic             busy,
  output logic             done
);
  import run_gen_pkg::*;

  generate
    if (GAP < 1 || GAP > (2 ** LEN_W) - 1) begin : g_bad_gap
      $error("run_gen: GAP must lie in 1..2**LEN_W-1");
    end
  endgenerate

  localparam logic [LEN_W-1:0] GAP_LOAD = LEN_W'(GAP - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_done;

  state_t           w_next_state;
  logic [LEN_W-1:0] w_next_cnt;
  logic             w_next_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= run_gen_pkg::IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_done  <= w_next_done;
    end
  end

  // The counter holds the number of cycles still to spend in RUN or GAP after this one.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_done  = 1'b0;
    case (r_state)
      run_gen_pkg::IDLE: begin
        if (start_valid) begin
          if (start_len == '0) begin
            w_next_done = 1'b1;
          end else begin
            w_next_state = run_gen_pkg::RUN;
            w_next_cnt   = start_len - ONE;
          end
        end
      end
      run_gen_pkg::RUN: begin
        if (r_cnt == '0) begin
          w_next_state = run_gen_pkg::GAP;
          w_next_cnt   = GAP_LOAD;
        end else begin
          w_next_cnt = r_cnt - ONE;
        end
      end
      run_gen_pkg::GAP: begin
        if (r_cnt == '0) begin
          w_next_state = run_gen_pkg::IDLE;
          w_next_done  = 1'b1;
        end else begin
          w_next_cnt = r_cnt - ONE;
        end
      end
      default: begin
        w_next_state = run_gen_pkg::IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign q           = (r_state == run_gen_pkg::RUN);
  assign busy        = (r_state != run_gen_pkg::IDLE);
  assign start_ready = (r_state == run_gen_pkg::IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_run_gen.sv
// tb/tb_run_gen.sv - checks three run_gen instances (GAP 1, 2, 15) against a timeline model
module tb_run_gen;

  logic       clk;
  logic       reset;
  logic [2:0] sv;
  logic [3:0] sl [3];
  logic [2:0] rdy_o, q_o, busy_o, done_o;

  run_gen #(.LEN_W(4), .GAP(1)) u_g1 (
    .clk(clk), .reset(reset), .start_valid(sv[0]), .start_len(sl[0]),
    .start_ready(rdy_o[0]), .q(q_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  run_gen #(.LEN_W(4), .GAP(2)) u_g2 (
    .clk(clk), .reset(reset), .start_valid(sv[1]), .start_len(sl[1]),
    .start_ready(rdy_o[1]), .q(q_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  run_gen #(.LEN_W(4), .GAP(15)) u_g15 (
    .clk(clk), .reset(reset), .start_valid(sv[2]), .start_len(sl[2]),
    .start_ready(rdy_o[2]), .q(q_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: each instance remembers only its last accepted request (edge index, length).
  int gv [3] = '{1, 2, 15};
  int cyc = 0;
  int acc_edge [3];
  int acc_len [3];
  bit active [3];
  bit accepted [3];
  int rises [3], dones [3], highs [3];
  logic [2:0] prev_q;

  function automatic int dd(int i);
    return cyc - acc_edge[i];
  endfunction

  function automatic logic e_q(int i);
    return active[i] && acc_len[i] != 0 && dd(i) >= 1 && dd(i) <= acc_len[i];
  endfunction

  function automatic logic e_busy(int i);
    return active[i] && acc_len[i] != 0 && dd(i) >= 1 && dd(i) <= acc_len[i] + gv[i];
  endfunction

  function automatic logic e_done(int i);
    if (!active[i]) return 1'b0;
    if (acc_len[i] == 0) return dd(i) == 1;
    return dd(i) == acc_len[i] + gv[i] + 1;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s inst=%0d cyc=%0d got=%0d exp=%0d", tag, i, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("q", i, q_o[i], e_q(i));
      chk("busy", i, busy_o[i], e_busy(i));
      chk("done", i, done_o[i], e_done(i));
      chk("start_ready", i, rdy_o[i], !e_busy(i));
      if (q_o[i] && !prev_q[i]) rises[i]++;
      if (q_o[i]) highs[i]++;
      if (done_o[i]) dones[i]++;
    end
    prev_q = q_o;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      rises[i] = 0; dones[i] = 0; highs[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (reset && sv[i] && !e_busy(i)) begin
        acc_edge[i] = cyc;
        acc_len[i]  = int'(sl[i]);
        active[i]   = 1'b1;
        accepted[i] = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send(input int i, input int len);
    int n;
    n = 0;
    sv[i] = 1'b1;
    sl[i] = 4'(len);
    accepted[i] = 1'b0;
    while (!accepted[i] && n < 64) begin
      step();
      n++;
    end
    chk("send_accepted_in_time", i, accepted[i], 1);
    sv[i] = 1'b0;
  endtask

  task automatic async_reset();
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) active[i] = 1'b0;
    #1 check_all();
  endtask

  initial begin
    reset = 1'b0;
    sv = '0;
    for (int i = 0; i < 3; i++) begin
      sl[i] = '0; active[i] = 1'b0; accepted[i] = 1'b0; acc_edge[i] = 0; acc_len[i] = 0;
    end
    prev_q = '0;
    clear_counts();
    #1 check_all();
    steps(2);
    reset = 1'b1;

    // L=3 on the GAP=1 instance: q high 3 cycles, 1 low, done on the 5th.
    send(0, 3);
    steps(6);

    // Zero-length request: only a done pulse.
    clear_counts();
    send(0, 0);
    steps(3);
    chk("zero_len_rises", 0, rises[0], 0);
    chk("zero_len_dones", 0, dones[0], 1);

    // Held back-to-back requests on GAP=2: second accepted on the done cycle.
    clear_counts();
    send(1, 2);
    send(1, 1);
    steps(6);
    chk("held_rises", 1, rises[1], 2);
    chk("held_dones", 1, dones[1], 2);

    // Async reset two cycles into an L=7 run.
    clear_counts();
    send(0, 7);
    step();
    async_reset();
    steps(2);
    chk("discarded_run_dones", 0, dones[0], 0);
    reset = 1'b1;
    clear_counts();
    send(0, 1);
    steps(4);
    chk("post_reset_highs", 0, highs[0], 1);
    chk("post_reset_dones", 0, dones[0], 1);

    // Longest run and longest gap: no counter wrap.
    clear_counts();
    send(2, 15);
    steps(35);
    chk("max_len_highs", 2, highs[2], 15);
    chk("max_len_rises", 2, rises[2], 1);
    chk("max_len_dones", 2, dones[2], 1);

    // Random valid/len traffic, including changes while busy.
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 3; i++) begin
        sv[i] = ($urandom_range(0, 2) == 0);
        sl[i] = 4'($urandom_range(0, 15));
      end
      step();
      if (k == 1000) begin
        async_reset();
        step();
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
